poly_mixer: RTL and testbench

Parametrised N-voice audio mixer that replaces the fixed four-input mixer between the waveform generators and the I2S interface. On each rising edge of the I2S left/right clock it snapshots all voice samples and gains. It then accumulates the enabled voices one per clock, applies master volume and drives one registered output sample with a valid strobe. Voice count, sample width and gain width are parameters, so voice count can grow without touching the mixer.

---
 rtl/poly_mixer_if.sv | 28 ++
 rtl/poly_mixer.sv | 194 +++++++++++++++++++
 tb/tb_poly_mixer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/poly_mixer_if.sv
// Bus bundle between a voice source (master) and poly_mixer (slave):
// snapshot inputs, mix controls and the mixed result with its status flags.
interface poly_mixer_if #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 8
);
    logic [NUM_CH*SAMPLE_W-1:0] samples;
    logic [NUM_CH*GAIN_W-1:0]   ch_gain;
    logic [NUM_CH-1:0]          ch_enable;
    logic [7:0]                 master_vol;
    logic                       flag_clr;
    logic [SAMPLE_W-1:0]        mixed_sample;
    logic                       sample_valid;
    logic                       busy;
    logic                       clip_flag;
    logic                       overrun;

    modport master (
        output samples, ch_gain, ch_enable, master_vol, flag_clr,
        input  mixed_sample, sample_valid, busy, clip_flag, overrun
    );

    modport slave (
        input  samples, ch_gain, ch_enable, master_vol, flag_clr,
        output mixed_sample, sample_valid, busy, clip_flag, overrun
    );
endinterface

// File: rtl/poly_mixer.sv
// N-voice mixer: snapshots all voices on each LRCLK rise, accumulates one voice per clock,
// applies master volume and emits one sample. Define MIXER_SATURATE_EN to clamp instead of wrap.
module poly_mixer #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_clk,
    poly_mixer_if.slave bus
);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TERM_W = SAMPLE_W + GAIN_W + 1;
    localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_CH) + 1;
    localparam int PROD_W = ACC_W + 8;
    localparam int SHIFT  = 8 + GAIN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic                       sync_1;
    logic                       sync_2;
    logic                       sync_d;
    logic                       rise;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc;
    logic [SAMPLE_W-1:0]        snap_sample [NUM_CH];
    logic [GAIN_W-1:0]          snap_gain [NUM_CH];
    logic [NUM_CH-1:0]          snap_enable;

    logic [SAMPLE_W-1:0]        cur_sample;
    logic [GAIN_W-1:0]          cur_gain;
    logic signed [TERM_W-1:0]   sample_ext;
    logic signed [TERM_W-1:0]   gain_ext;
    logic signed [TERM_W-1:0]   term;
    logic signed [ACC_W-1:0]    term_acc;
    logic signed [PROD_W-1:0]   acc_ext;
    logic signed [PROD_W-1:0]   vol_ext;
    logic signed [PROD_W-1:0]   scaled;
    logic [SAMPLE_W-1:0]        mix_result;

    logic [SAMPLE_W-1:0]        mixed_r;
    logic                       valid_r;
    logic                       overrun_r;

    // LRCLK is asynchronous to clk: two flops to resynchronise, a third to find the rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync_1 <= sample_clk;
            sync_2 <= sync_1;
            sync_d <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rise) state_next = ACCUM;
            ACCUM:   if (idx == LAST_IDX) state_next = SCALE;
            SCALE:   state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gain is unsigned, so it is zero-extended before joining the signed multiply.
    assign cur_sample = snap_sample[idx];
    assign cur_gain   = snap_gain[idx];
    assign sample_ext = TERM_W'($signed(cur_sample));
    assign gain_ext   = TERM_W'(cur_gain);
    assign term       = sample_ext * gain_ext;
    assign term_acc   = ACC_W'(term);

    assign acc_ext = PROD_W'(acc);
    assign vol_ext = PROD_W'(bus.master_vol);
    assign scaled  = acc_ext * vol_ext;

`ifdef MIXER_SATURATE_EN
    logic signed [PROD_W-1:0] shifted;
    logic                     over_hi;
    logic                     over_lo;
    logic                     clip_r;

    // Result is in range only when every bit above the SAMPLE_W sign bit matches the product sign.
    assign shifted = scaled >>> SHIFT;
    assign over_hi = ~shifted[PROD_W-1] & (|shifted[PROD_W-2:SAMPLE_W-1]);
    assign over_lo = shifted[PROD_W-1] & ~(&shifted[PROD_W-2:SAMPLE_W-1]);

    always_comb begin
        mix_result = shifted[SAMPLE_W-1:0];
        if (over_hi) begin
            mix_result = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (over_lo) begin
            mix_result = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_r <= 1'b0;
        end else if (state == SCALE && (over_hi || over_lo)) begin
            clip_r <= 1'b1;
        end else if (bus.flag_clr) begin
            clip_r <= 1'b0;
        end
    end

    assign bus.clip_flag = clip_r;
`else
    assign mix_result    = SAMPLE_W'(scaled >>> SHIFT);
    assign bus.clip_flag = 1'b0;
`endif

    // The result is registered at the end of SCALE so it is visible, with its strobe, during OUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            acc         <= '0;
            snap_enable <= '0;
            mixed_r     <= '0;
            valid_r     <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_sample[k] <= '0;
                snap_gain[k]   <= '0;
            end
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            snap_sample[k] <= bus.samples[k*SAMPLE_W +: SAMPLE_W];
                            snap_gain[k]   <= bus.ch_gain[k*GAIN_W +: GAIN_W];
                        end
                        snap_enable <= bus.ch_enable;
                        acc         <= '0;
                        idx         <= '0;
                    end
                end
                ACCUM: begin
                    if (snap_enable[idx]) begin
                        acc <= acc + term_acc;
                    end
                    idx <= idx + IDX_W'(1);
                end
                SCALE: begin
                    mixed_r <= mix_result;
                    valid_r <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // A rise while a mix is in flight is dropped; a simultaneous clear loses to the set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
        end else if (rise && state != IDLE) begin
            overrun_r <= 1'b1;
        end else if (bus.flag_clr) begin
            overrun_r <= 1'b0;
        end
    end

    assign bus.mixed_sample = mixed_r;
    assign bus.sample_valid = valid_r;
    assign bus.busy         = (state != IDLE);
    assign bus.overrun      = overrun_r;
endmodule

// File: tb/tb_poly_mixer.sv
// Directed bench for poly_mixer with NUM_CH=4, SAMPLE_W=24, GAIN_W=8.
// Expected values are hand-computed; clamp or wrap expectations follow MIXER_SATURATE_EN.
module tb_poly_mixer;
    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 24;
    localparam int GAIN_W   = 8;

`ifdef MIXER_SATURATE_EN
    localparam logic [23:0] EXP_POS  = 24'h7FFFFF;
    localparam logic [23:0] EXP_NEG  = 24'h800000;
    localparam logic [31:0] EXP_CLIP = 32'd1;
`else
    localparam logic [23:0] EXP_POS  = 24'hFC01FC;
    localparam logic [23:0] EXP_NEG  = 24'h03FE00;
    localparam logic [31:0] EXP_CLIP = 32'd0;
`endif

    logic clk;
    logic reset_n;
    logic sample_clk;
    int   n_assert;
    int   n_fail;

    poly_mixer_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) bus ();

    poly_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_clk (sample_clk),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [23:0] s0, input logic [23:0] s1,
                                  input logic [23:0] s2, input logic [23:0] s3,
                                  input logic [7:0] g0, input logic [7:0] g1,
                                  input logic [7:0] g2, input logic [7:0] g3,
                                  input logic [3:0] en, input logic [7:0] vol);
        bus.samples    = {s3, s2, s1, s0};
        bus.ch_gain    = {g3, g2, g1, g0};
        bus.ch_enable  = en;
        bus.master_vol = vol;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.flag_clr = 1'b1;
        @(negedge clk);
        bus.flag_clr = 1'b0;
    endtask

    // mode 0: plain mix, 1: zero the samples at E+2, 2: second rise at E+3, 3: reset at E+2
    task automatic mix_and_check(input string tag, input int mode, input logic [23:0] exp_sample);
        int          busy_at;
        int          valid_at;
        int          n_valid;
        logic [23:0] got;
        busy_at  = -1;
        valid_at = -1;
        n_valid  = 0;
        got      = '0;
        @(negedge clk);
        sample_clk = 1'b1;
        @(negedge clk);
        sample_clk = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.busy && busy_at < 0) busy_at = c;
            if (bus.sample_valid) begin
                n_valid++;
                if (valid_at < 0) begin
                    valid_at = c;
                    got      = bus.mixed_sample;
                end
            end
            if (mode == 3 && busy_at >= 0 && c == busy_at + 2) begin
                check_output({tag, "_rst_sample"}, 32'(bus.mixed_sample), 32'd0);
                check_output({tag, "_rst_valid"}, 32'(bus.sample_valid), 32'd0);
                check_output({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
                check_output({tag, "_rst_clip"}, 32'(bus.clip_flag), 32'd0);
                check_output({tag, "_rst_overrun"}, 32'(bus.overrun), 32'd0);
            end
            if (mode == 1 && busy_at >= 0 && c == busy_at + 1) bus.samples = '0;
            if (mode == 2 && c == 1) sample_clk = 1'b1;
            if (mode == 2 && c == 2) sample_clk = 1'b0;
            if (mode == 3 && busy_at >= 0 && c == busy_at + 1) reset_n = 1'b0;
            if (mode == 3 && busy_at >= 0 && c == busy_at + 3) reset_n = 1'b1;
        end
        if (mode == 3) begin
            check_output({tag, "_valid_count"}, 32'(n_valid), 32'd0);
        end else begin
            check_output({tag, "_valid_count"}, 32'(n_valid), 32'd1);
            check_output({tag, "_latency"}, 32'(valid_at - busy_at), 32'(NUM_CH + 1));
            check_output({tag, "_sample"}, 32'(got), 32'(exp_sample));
        end
        check_output({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check_output({tag, "_overrun"}, 32'(bus.overrun), (mode == 2) ? 32'd1 : 32'd0);
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        sample_clk   = 1'b0;
        bus.flag_clr = 1'b0;
        apply_stimulus(24'h0, 24'h0, 24'h0, 24'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 8'd0);
        repeat (3) @(negedge clk);
        check_output("reset_sample", 32'(bus.mixed_sample), 32'd0);
        check_output("reset_valid", 32'(bus.sample_valid), 32'd0);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_clip", 32'(bus.clip_flag), 32'd0);
        check_output("reset_overrun", 32'(bus.overrun), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single voice");
        apply_stimulus(24'h100000, 24'h123456, 24'h0ABCDE, 24'h654321,
                       8'd128, 8'd200, 8'd77, 8'd255, 4'b0001, 8'd128);
        mix_and_check("single", 0, 24'h040000);

        $display("[TB] masking");
        apply_stimulus(24'd1000, 24'd5000, 24'd3000, 24'd7000,
                       8'd255, 8'd255, 8'd255, 8'd255, 4'b0101, 8'd255);
        mix_and_check("mask", 0, 24'd3968);

        $display("[TB] all voices disabled");
        apply_stimulus(24'd1000, 24'd5000, 24'd3000, 24'd7000,
                       8'd255, 8'd255, 8'd255, 8'd255, 4'b0000, 8'd255);
        mix_and_check("disabled", 0, 24'h000000);

        $display("[TB] all gains zero");
        apply_stimulus(24'd1000, 24'd5000, 24'd3000, 24'd7000,
                       8'd0, 8'd0, 8'd0, 8'd0, 4'b1111, 8'd255);
        mix_and_check("zero_gain", 0, 24'h000000);

        $display("[TB] floor rounding of a negative result");
        apply_stimulus(24'hFFFFFF, 24'h0, 24'h0, 24'h0,
                       8'd1, 8'd0, 8'd0, 8'd0, 4'b0001, 8'd1);
        mix_and_check("floor", 0, 24'hFFFFFF);

        $display("[TB] positive full scale");
        apply_stimulus(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
                       8'd255, 8'd255, 8'd255, 8'd255, 4'b1111, 8'd255);
        mix_and_check("sat_pos", 0, EXP_POS);
        check_output("sat_pos_clip", 32'(bus.clip_flag), EXP_CLIP);

        $display("[TB] negative full scale");
        apply_stimulus(24'h800000, 24'h800000, 24'h800000, 24'h800000,
                       8'd255, 8'd255, 8'd255, 8'd255, 4'b1111, 8'd255);
        mix_and_check("sat_neg", 0, EXP_NEG);
        check_output("sat_neg_clip", 32'(bus.clip_flag), EXP_CLIP);
        pulse_clear();
        check_output("clip_cleared", 32'(bus.clip_flag), 32'd0);

        $display("[TB] snapshot isolation");
        apply_stimulus(24'h100000, 24'h010000, 24'h0, 24'h0,
                       8'd128, 8'd255, 8'd0, 8'd0, 4'b0011, 8'd128);
        mix_and_check("snapshot", 1, 24'h047F80);

        $display("[TB] overrun");
        apply_stimulus(24'h100000, 24'h010000, 24'h0, 24'h0,
                       8'd128, 8'd255, 8'd0, 8'd0, 4'b0011, 8'd128);
        mix_and_check("overrun", 2, 24'h047F80);
        pulse_clear();
        check_output("overrun_cleared", 32'(bus.overrun), 32'd0);

        $display("[TB] reset mid-mix");
        apply_stimulus(24'h100000, 24'h123456, 24'h0ABCDE, 24'h654321,
                       8'd128, 8'd200, 8'd77, 8'd255, 4'b0001, 8'd128);
        mix_and_check("reset_mid", 3, 24'h000000);
        mix_and_check("after_reset", 0, 24'h040000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
